// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the fetch stage: default widths, reset PC and instruction encoding helpers.
package instruction_fetch_pkg;
  localparam int          IF_WIDTH      = 32;
  localparam int          IF_MEM_SIZE   = 1024;
  localparam int unsigned IF_RESET_PC   = 0;
  localparam int          IF_FIFO_DEPTH = 2;
  localparam int          INST_BYTES    = 4;
  localparam logic [31:0] NOP           = 32'h0000_0013;
endpackage

// File: rtl/instruction_fetch_fifo.sv
// Synchronous fetch buffer holding {inst, pc} pairs; flush wins over push.
module instruction_fetch_fifo
  import instruction_fetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop, full;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & (count != '0);
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // Credit logic upstream must make a push into a full, non-popping buffer impossible.
      assert (!(push && full && !pop));
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/instruction_fetch.sv
// PC generator and fetch buffer in front of a 1-cycle-latency instruction memory,
// with credit-based issue and redirect squash of the in-flight read.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int          WIDTH1     = IF_WIDTH,
  parameter int          MEM_SIZE   = IF_MEM_SIZE,
  parameter int unsigned RESET_PC   = IF_RESET_PC,
  parameter int          FIFO_DEPTH = IF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  output logic [WIDTH1-1:0] imem_addr,
  input  logic [WIDTH1-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [WIDTH1-1:0] inst,
  output logic [WIDTH1-1:0] inst_pc,
  input  logic              redirect,
  input  logic [WIDTH1-1:0] redirect_pc
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [WIDTH1-1:0]   pc, req_pc;
  logic                inflight, issue, push, pop;
  logic [CW-1:0]       count;
  logic [CW:0]         occ_after_pop;
  logic [2*WIDTH1-1:0] head;

  assign imem_addr  = (pc >> 2) & WIDTH1'(MEM_SIZE - 1);
  assign inst_valid = (count != '0) & ~redirect;
  assign pop        = inst_valid & inst_ready;
  assign push       = inflight & ~redirect;

  // The outstanding read already owns a slot, so it counts against capacity.
  assign occ_after_pop = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue         = fetch_en & ~redirect & (occ_after_pop < (CW+1)'(FIFO_DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= WIDTH1'(RESET_PC);
      req_pc   <= '0;
      inflight <= 1'b0;
    end else if (redirect) begin
      pc       <= {redirect_pc[WIDTH1-1:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc     <= pc + WIDTH1'(INST_BYTES);
        req_pc <= pc;
      end
    end
  end

  instruction_fetch_fifo #(
    .WIDTH (2*WIDTH1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ({imem_rdata, req_pc}),
    .dout  (head),
    .count (count)
  );

  assign inst    = head[2*WIDTH1-1:WIDTH1];
  assign inst_pc = head[WIDTH1-1:0];
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: scoreboard of expected {inst, pc} pairs,
// behavioural 1-cycle-latency memory, plus a second instance started near the top of memory.
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_en = 1'b0;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_addr, imem_rdata, inst, inst_pc;
  logic        inst_valid;

  logic        w_redirect = 1'b0;
  logic [31:0] w_redirect_pc = 32'h0;
  logic [31:0] w_imem_addr, w_rdata, w_inst, w_pc;
  logic        w_valid;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  exp_t wq[$];
  int   total = 0;
  int   bad = 0;
  int   npop = 0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  instruction_fetch #(.RESET_PC(4*1024 - 8)) dut_wrap (
    .clk         (clk),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .imem_addr   (w_imem_addr),
    .imem_rdata  (w_rdata),
    .inst_valid  (w_valid),
    .inst_ready  (inst_ready),
    .inst        (w_inst),
    .inst_pc     (w_pc),
    .redirect    (w_redirect),
    .redirect_pc (w_redirect_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] word);
    logic [9:0] idx;
    idx = word[9:0];
    return (idx == 10'd0) ? 32'h0150_0093 : {6'h2B, idx, 6'h00, idx};
  endfunction

  always @(posedge clk) begin
    imem_rdata <= mem_word(imem_addr);
    w_rdata    <= mem_word(w_imem_addr);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic push_seq(input logic [31:0] start, input int n, input bit to_wrap);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc   = start + 32'(4*i);
      e.inst = mem_word(e.pc >> 2);
      if (to_wrap) wq.push_back(e);
      else         q.push_back(e);
    end
  endtask

  // One clock: observe at the falling edge, let the rising edge happen, return just after it.
  task automatic cyc(input int ev, input bit hold);
    exp_t e;
    @(negedge clk);
    if (ev >= 0) check("valid", 64'(inst_valid), 64'(ev));
    if (hold && q.size() > 0) begin
      check("hold_inst", 64'(inst), 64'(q[0].inst));
      check("hold_pc", 64'(inst_pc), 64'(q[0].pc));
    end
    if (inst_valid && inst_ready) begin
      npop++;
      check("sb_nonempty", 64'(q.size() != 0), 64'(1));
      if (q.size() != 0) begin
        e = q.pop_front();
        check("inst", 64'(inst), 64'(e.inst));
        check("inst_pc", 64'(inst_pc), 64'(e.pc));
      end
    end
    if (w_valid && inst_ready && wq.size() > 0) begin
      e = wq.pop_front();
      check("wrap_inst", 64'(w_inst), 64'(e.inst));
      check("wrap_pc", 64'(w_pc), 64'(e.pc));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    fetch_en   = 1'b1;
    inst_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr", 64'(imem_addr), 64'(0));
    check("rst_valid", 64'(inst_valid), 64'(0));
    check("rst_inst", 64'(inst), 64'(0));
    check("rst_pc", 64'(inst_pc), 64'(0));
    check("rst_wrap_addr", 64'(w_imem_addr), 64'(1022));

    // Reset release and streaming
    push_seq(32'h0, 40, 1'b0);
    push_seq(32'hFF8, 4, 1'b1);
    reset = 1'b0;
    cyc(0, 0);
    cyc(0, 0);
    for (int i = 0; i < 22; i++) cyc(1, 0);
    check("stream_count", 64'(npop), 64'(22));
    check("wrap_drained", 64'(wq.size()), 64'(0));

    // Back-pressure
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1, 1);
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1, 0);
    check("bp_count", 64'(npop), 64'(26));

    // Async reset mid-cycle
    #2;
    reset = 1'b1;
    #1;
    check("areset_valid", 64'(inst_valid), 64'(0));
    check("areset_addr", 64'(imem_addr), 64'(0));
    check("areset_pc", 64'(inst_pc), 64'(0));
    q.delete();
    cyc(0, 0);
    reset = 1'b0;
    push_seq(32'h0, 8, 1'b0);
    cyc(0, 0);
    cyc(0, 0);
    cyc(1, 0);
    cyc(1, 0);

    // Redirect while inst_pc=8 is at the head
    redirect    = 1'b1;
    redirect_pc = 32'h2E;
    q.delete();
    push_seq(32'h2C, 20, 1'b0);
    cyc(0, 0);
    redirect = 1'b0;
    cyc(0, 0);
    cyc(0, 0);
    base = npop;
    cyc(1, 0);
    check("redir_first", 64'(npop - base), 64'(1));
    for (int i = 0; i < 3; i++) cyc(1, 0);

    // Fill the buffer, then drain with fetch disabled
    inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1, 1);
    fetch_en   = 1'b0;
    inst_ready = 1'b1;
    base = npop;
    for (int i = 0; i < 6; i++) cyc(-1, 0);
    check("drain_count", 64'(npop - base), 64'(2));
    cyc(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
